// File: rtl/se_sram_srw_master.sv
// Valid/ready front end for a single-port synchronous SRAM: registers commands onto
// the SRAM pins and returns read data in order through a credit-protected response FIFO.
module se_sram_srw_master #(
  parameter int address_width = 16,
  parameter int data_width    = 16,
  parameter int rsp_depth     = 4
) (
  input  logic                     sram_clock,
  input  logic                     sram_reset,
  input  logic                     sram_clock__enable,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_read_not_write,
  input  logic [address_width-1:0] req_address,
  input  logic [data_width-1:0]    req_write_data,
  input  logic                     req_write_enable,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [data_width-1:0]    rsp_data,
  output logic                     sram_select,
  output logic                     sram_read_not_write,
  output logic                     sram_write_enable,
  output logic [address_width-1:0] sram_address,
  output logic [data_width-1:0]    sram_write_data,
  input  logic [data_width-1:0]    sram_data_out,
  output logic                     busy
);

  localparam int ptr_w = (rsp_depth > 1) ? $clog2(rsp_depth) : 1;
  localparam int cnt_w = $clog2(rsp_depth + 1);
  localparam int occ_w = $clog2(rsp_depth + 3) + 1;

  // Handshakes: a transfer happens at the enabled rising edge where valid & ready are
  // both high; ready never depends on valid, and valid/data hold until taken.

  logic                     c_select;
  logic                     c_read_not_write;
  logic                     c_write_enable;
  logic [address_width-1:0] c_address;
  logic [data_width-1:0]    c_write_data;
  logic                     p_pending;
  logic [data_width-1:0]    fifo_mem [rsp_depth];
  logic [ptr_w-1:0]         f_head;
  logic [ptr_w-1:0]         f_tail;
  logic [cnt_w-1:0]         f_count;

  logic                     c_read;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic [occ_w-1:0]         occupancy;
  logic [occ_w-1:0]         credit_limit;

  function automatic logic [ptr_w-1:0] ptr_next(input logic [ptr_w-1:0] ptr);
    return (ptr == ptr_w'(rsp_depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign c_read    = c_select & c_read_not_write;
  assign rsp_valid = (f_count != '0);
  assign rsp_data  = rsp_valid ? fifo_mem[f_head] : '0;
  assign push      = sram_clock__enable & p_pending;
  assign pop       = sram_clock__enable & rsp_valid & rsp_ready;

  // Every read already committed (queued, on the SRAM bus, or in C) owns a FIFO slot;
  // a response leaving at this edge frees its slot for the new request.
  assign occupancy    = occ_w'(f_count) + occ_w'(p_pending) + occ_w'(c_read);
  assign credit_limit = occ_w'(rsp_depth) + occ_w'(pop);
  assign req_ready    = sram_clock__enable & ~sram_reset & (occupancy < credit_limit);
  assign accept       = req_valid & req_ready;

  assign busy = c_select | p_pending | (f_count != '0);

  assign sram_select         = c_select;
  assign sram_read_not_write = c_read_not_write;
  assign sram_write_enable   = c_write_enable;
  assign sram_address        = c_address;
  assign sram_write_data     = c_write_data;

  always_ff @(posedge sram_clock or posedge sram_reset) begin
    if (sram_reset) begin
      c_select         <= 1'b0;
      c_read_not_write <= 1'b1;
      c_write_enable   <= 1'b0;
      c_address        <= '0;
      c_write_data     <= '0;
    end else if (sram_clock__enable) begin
      if (accept) begin
        c_select         <= 1'b1;
        c_read_not_write <= req_read_not_write;
        c_write_enable   <= req_write_enable & ~req_read_not_write;
        c_address        <= req_address;
        c_write_data     <= req_write_data;
      end else begin
        c_select       <= 1'b0;
        c_write_enable <= 1'b0;
      end
    end
  end

  always_ff @(posedge sram_clock or posedge sram_reset) begin
    if (sram_reset) begin
      p_pending <= 1'b0;
    end else if (sram_clock__enable) begin
      p_pending <= c_read;
    end
  end

  // Pointer/count bookkeeping; storage below carries no reset since rsp_data is gated.
  always_ff @(posedge sram_clock or posedge sram_reset) begin
    if (sram_reset) begin
      f_head  <= '0;
      f_tail  <= '0;
      f_count <= '0;
    end else begin
      if (push) f_tail <= ptr_next(f_tail);
      if (pop)  f_head <= ptr_next(f_head);
      case ({push, pop})
        2'b10:   f_count <= f_count + 1'b1;
        2'b01:   f_count <= f_count - 1'b1;
        default: f_count <= f_count;
      endcase
    end
  end

  always_ff @(posedge sram_clock) begin
    if (push) fifo_mem[f_tail] <= sram_data_out;
  end

endmodule

// File: tb/tb_se_sram_srw_master.sv
// Scoreboard bench for se_sram_srw_master: a behavioural SRAM, an in-order reference
// memory that predicts read data at acceptance time, and a monitor that pops responses.
module tb_se_sram_srw_master;

  localparam int AW        = 16;
  localparam int DW        = 16;
  localparam int RSP_DEPTH = 4;

  logic          sram_clock = 1'b0;
  logic          sram_reset;
  logic          sram_clock__enable;
  logic          req_valid;
  logic          req_ready;
  logic          req_read_not_write;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_write_data;
  logic          req_write_enable;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          sram_select;
  logic          sram_read_not_write;
  logic          sram_write_enable;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_write_data;
  logic [DW-1:0] sram_data_out;
  logic          busy;

  se_sram_srw_master #(
    .address_width(AW),
    .data_width(DW),
    .rsp_depth(RSP_DEPTH)
  ) dut (
    .sram_clock(sram_clock),
    .sram_reset(sram_reset),
    .sram_clock__enable(sram_clock__enable),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_read_not_write(req_read_not_write),
    .req_address(req_address),
    .req_write_data(req_write_data),
    .req_write_enable(req_write_enable),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .sram_select(sram_select),
    .sram_read_not_write(sram_read_not_write),
    .sram_write_enable(sram_write_enable),
    .sram_address(sram_address),
    .sram_write_data(sram_write_data),
    .sram_data_out(sram_data_out),
    .busy(busy)
  );

  // Clock and behavioural single-port SRAM gated by the same enable.
  always #5 sram_clock = ~sram_clock;

  logic [DW-1:0] sram_mem [64];
  always @(posedge sram_clock) begin
    if (sram_clock__enable && sram_select) begin
      if (sram_read_not_write) sram_data_out <= sram_mem[sram_address[5:0]];
      else if (sram_write_enable) sram_mem[sram_address[5:0]] <= sram_write_data;
    end
  end

  // Scoreboard state.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [64];
  int vectors     = 0;
  int miscompares = 0;
  int stalls      = 0;
  int rsp_seen    = 0;
  int seen0;
  bit rb_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Driver: hold a command until accepted; the model sees commands in acceptance order.
  task automatic issue(input logic rnw, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic we);
    int  waited = 0;
    bit  done   = 0;
    req_valid          = 1'b1;
    req_read_not_write = rnw;
    req_address        = addr;
    req_write_data     = data;
    req_write_enable   = we;
    while (!done) begin
      @(negedge sram_clock);
      if (req_ready) begin
        if (rnw) exp_q.push_back(ref_mem[addr[5:0]]);
        else if (we) ref_mem[addr[5:0]] = data;
        done = 1;
      end else begin
        waited++;
        if (waited > 200) begin
          fail_now("req_accept_timeout");
          done = 1;
        end
      end
      @(posedge sram_clock);
      #1;
    end
    stalls += waited;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge sram_clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    repeat (2) @(posedge sram_clock);
    #1;
  endtask

  // Monitor: compares every handshaken response against the queue head.
  always @(negedge sram_clock) begin
    if (!sram_reset && sram_clock__enable) begin
      if (rsp_valid && rsp_ready) begin
        rsp_seen++;
        if (exp_q.size() == 0) fail_now("unexpected_rsp");
        else check("rsp_data", rsp_data, exp_q.pop_front());
      end
      if (!rsp_valid) check("rsp_data_zero_when_idle", rsp_data, 0);
      if (dut.p_pending && int'(dut.f_count) == RSP_DEPTH && !(rsp_valid && rsp_ready))
        fail_now("fifo_overflow");
    end
  end

  initial begin
    #2_000_000;
    fail_now("watchdog");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    sram_reset         = 1'b1;
    sram_clock__enable = 1'b1;
    req_valid          = 1'b0;
    req_read_not_write = 1'b0;
    req_address        = '0;
    req_write_data     = '0;
    req_write_enable   = 1'b0;
    rsp_ready          = 1'b1;
    repeat (3) @(posedge sram_clock);
    #1 sram_reset = 1'b0;
    #1;
    check("reset_req_ready", req_ready, 1);
    check("reset_sram_select", sram_select, 0);
    check("reset_sram_rnw", sram_read_not_write, 1);
    check("reset_sram_we", sram_write_enable, 0);
    check("reset_sram_address", sram_address, 0);
    check("reset_sram_wdata", sram_write_data, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_busy", busy, 0);
    @(posedge sram_clock);
    #1;

    // Fill the small address window so every later read has a known value.
    for (int i = 0; i < 64; i++) issue(1'b0, AW'(i), DW'($urandom), 1'b1);
    drain();

    // Write then read, with cycle-exact pin and latency checks.
    issue(1'b0, 16'h0010, 16'h1234, 1'b1);
    check("wr_select", sram_select, 1);
    check("wr_rnw", sram_read_not_write, 0);
    check("wr_we", sram_write_enable, 1);
    check("wr_address", sram_address, 16'h0010);
    check("wr_wdata", sram_write_data, 16'h1234);
    issue(1'b1, 16'h0010, 16'h0000, 1'b0);
    check("rd_select", sram_select, 1);
    check("rd_rnw", sram_read_not_write, 1);
    @(posedge sram_clock);
    #1 check("rd_no_rsp_early", rsp_valid, 0);
    @(posedge sram_clock);
    #1 check("rd_rsp_valid_n4", rsp_valid, 1);
    check("rd_rsp_data_n4", rsp_data, 16'h1234);
    drain();

    // Read stream under backpressure.
    for (int i = 0; i < 8; i++) issue(1'b0, AW'(i), DW'(i * 3), 1'b1);
    drain();
    rsp_ready = 1'b0;
    stalls    = 0;
    seen0     = rsp_seen;
    for (int i = 0; i < 4; i++) issue(1'b1, AW'(i), '0, 1'b0);
    check("bp_four_accepts_no_stall", stalls, 0);
    req_valid          = 1'b1;
    req_read_not_write = 1'b1;
    req_address        = 16'd4;
    for (int k = 0; k < 3; k++) begin
      @(negedge sram_clock);
      check("bp_req_ready_low", req_ready, 0);
      @(posedge sram_clock);
      #1;
    end
    check("bp_rsp_valid_held", rsp_valid, 1);
    check("bp_rsp_head", rsp_data, 0);
    rsp_ready = 1'b1;
    for (int i = 4; i < 8; i++) issue(1'b1, AW'(i), '0, 1'b0);
    drain();
    check("bp_rsp_count", rsp_seen - seen0, 8);

    // Clock enable low for 3 cycles in the middle of a read stream.
    fork
      begin
        for (int i = 0; i < 16; i++) issue(1'b1, AW'($urandom_range(0, 63)), '0, 1'b0);
      end
      begin
        repeat (6) @(posedge sram_clock);
        #1 sram_clock__enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge sram_clock);
          check("en_low_req_ready", req_ready, 0);
          check("en_low_select_held", sram_select, 1);
          check("en_low_rsp_valid_held", rsp_valid, 1);
          if (exp_q.size() != 0) check("en_low_rsp_data_held", rsp_data, exp_q[0]);
          @(posedge sram_clock);
          #1;
        end
        sram_clock__enable = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two reads in flight and one response held.
    rsp_ready = 1'b0;
    issue(1'b1, 16'd5, '0, 1'b0);
    for (int n = 0; n < 20 && !rsp_valid; n++) begin
      @(posedge sram_clock);
      #1;
    end
    check("rst_setup_rsp_held", rsp_valid, 1);
    issue(1'b1, 16'd6, '0, 1'b0);
    issue(1'b1, 16'd7, '0, 1'b0);
    #1 sram_reset = 1'b1;
    #1;
    check("arst_select", sram_select, 0);
    check("arst_rnw", sram_read_not_write, 1);
    check("arst_we", sram_write_enable, 0);
    check("arst_address", sram_address, 0);
    check("arst_wdata", sram_write_data, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_data", rsp_data, 0);
    check("arst_busy", busy, 0);
    exp_q.delete();
    @(posedge sram_clock);
    #1 sram_reset = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge sram_clock);
      check("post_reset_no_rsp", rsp_valid, 0);
      @(posedge sram_clock);
      #1;
    end
    seen0 = rsp_seen;
    issue(1'b1, 16'd9, '0, 1'b0);
    drain();
    check("post_reset_read_count", rsp_seen - seen0, 1);

    // Random traffic with random response backpressure.
    rb_done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++)
          issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), DW'($urandom),
                1'($urandom_range(0, 7) != 0));
        rb_done = 1;
      end
      begin
        while (!rb_done) begin
          @(posedge sram_clock);
          #1 rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    drain();

    // Full throughput with the consumer always ready.
    stalls = 0;
    for (int i = 0; i < 1000; i++)
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), DW'($urandom),
            1'($urandom_range(0, 7) != 0));
    check("throughput_stall_cycles", stalls, 0);
    drain();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
